vga_timing_gen: RTL and testbench

Parametrised successor to the fixed 640x480 VGA controller: generates horizontal/vertical timing, coordinates, blanking, and frame/line markers for any resolution and sync polarity. Instead of a divided clock it produces a pixel clock-enable from the single system clock. It adds run/stop control that always finishes the current frame cleanly, plus a frame counter. It sits between the system clock domain and the video DAC/pixel pipeline, feeding sprite/colour logic through DrawX/DrawY.

---
 rtl/vga_timing_gen.sv | 147 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel clock-enable, DrawX/DrawY, syncs,
// blanking, line/frame markers and a frame counter, with run/stop control.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned FRAME_W  = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               En,
  output logic               pixel_ce,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic               sync,
  output logic               line_start,
  output logic               frame_start,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [DIV_W-1:0]   div, div_nx;
  logic [COORD_W-1:0] hc_nx, vc_nx;
  logic [FRAME_W-1:0] fc_nx;
  logic               ce_nx, hs_nx, vs_nx, blank_nx, ls_nx, fs_nx, busy_nx;
  logic               h_wrap, v_wrap, advance;

  assign h_wrap  = (DrawX == H_LAST);
  assign v_wrap  = (DrawY == V_LAST);
  assign advance = pixel_ce && (state != IDLE);
  assign sync    = 1'b0;

  // Next-state, next-counter and decode of every registered output
  always_comb begin
    state_nx = state;
    div_nx   = (div == DIV_LAST) ? '0 : div + 1'b1;
    ce_nx    = (div == DIV_LAST);
    hc_nx    = DrawX;
    vc_nx    = DrawY;
    fc_nx    = frame_count;
    ls_nx    = 1'b0;
    fs_nx    = 1'b0;

    case (state)
      IDLE: begin
        if (pixel_ce && En) begin
          state_nx = RUN;
          ls_nx    = 1'b1;
          fs_nx    = 1'b1;
        end
      end
      RUN: begin
        if (!En) state_nx = STOPPING;
      end
      STOPPING: begin
        if (En)                              state_nx = RUN;
        else if (pixel_ce && h_wrap && v_wrap) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (advance) begin
      if (h_wrap) begin
        hc_nx = '0;
        if (v_wrap) begin
          vc_nx = '0;
          fc_nx = frame_count + 1'b1;
        end else begin
          vc_nx = DrawY + 1'b1;
        end
      end else begin
        hc_nx = DrawX + 1'b1;
      end
      // No markers on the final wrap that drops back to IDLE
      ls_nx = h_wrap && (state_nx != IDLE);
      fs_nx = h_wrap && v_wrap && (state_nx != IDLE);
    end

    busy_nx  = (state_nx != IDLE);
    hs_nx    = (busy_nx && (32'(hc_nx) >= HS_START) && (32'(hc_nx) < HS_END)) ? HS_POL : ~HS_POL;
    vs_nx    = (busy_nx && (32'(vc_nx) >= VS_START) && (32'(vc_nx) < VS_END)) ? VS_POL : ~VS_POL;
    blank_nx = busy_nx && (32'(hc_nx) < H_ACTIVE) && (32'(vc_nx) < V_ACTIVE);
  end

  // State, counters and registered outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      div         <= '0;
      pixel_ce    <= 1'b0;
      DrawX       <= '0;
      DrawY       <= '0;
      frame_count <= '0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nx;
      div         <= div_nx;
      pixel_ce    <= ce_nx;
      DrawX       <= hc_nx;
      DrawY       <= vc_nx;
      frame_count <= fc_nx;
      hs          <= hs_nx;
      vs          <= vs_nx;
      blank       <= blank_nx;
      line_start  <= ls_nx;
      frame_start <= fs_nx;
      busy        <= busy_nx;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing (line level, CLK_DIV=2) and a tiny
// 8x6 mode (CLK_DIV=1, active-high syncs) for frame, stop and reset cases.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst0, en0, pce0, hs0, vs0, blank0, sync0, ls0, fs0, busy0;
  logic [9:0]  x0, y0;
  logic [15:0] fc0;

  vga_timing_gen dut0 (
    .Clk(clk), .Reset(rst0), .En(en0), .pixel_ce(pce0), .DrawX(x0), .DrawY(y0),
    .hs(hs0), .vs(vs0), .blank(blank0), .sync(sync0), .line_start(ls0),
    .frame_start(fs0), .busy(busy0), .frame_count(fc0)
  );

  // Small-mode instance: H 4/1/2/1, V 3/1/1/1, CLK_DIV=1, positive syncs
  logic        rst1, en1, pce1, hs1, vs1, blank1, sync1, ls1, fs1, busy1;
  logic [3:0]  x1, y1;
  logic [3:0]  fc1;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .COORD_W(4), .FRAME_W(4)
  ) dut1 (
    .Clk(clk), .Reset(rst1), .En(en1), .pixel_ce(pce1), .DrawX(x1), .DrawY(y1),
    .hs(hs1), .vs(vs1), .blank(blank1), .sync(sync1), .line_start(ls1),
    .frame_start(fs1), .busy(busy1), .frame_count(fc1)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         cyc;
    logic       en;
    logic [3:0] x;
    logic [3:0] y;
    logic       hs, vs, blank, ls, fs, busy;
  } vec_t;

  function automatic vec_t mk(input int cyc, input logic [3:0] x, input logic [3:0] y,
                              input logic hs, input logic vs, input logic blank,
                              input logic ls, input logic fs, input logic busy);
    vec_t v;
    v.cyc = cyc; v.en = 1'b1; v.x = x; v.y = y;
    v.hs = hs; v.vs = vs; v.blank = blank; v.ls = ls; v.fs = fs; v.busy = busy;
    return v;
  endfunction

  vec_t vt[13];

  // pixel_ce of the CLK_DIV=1 instance must never drop while running
  logic mon1 = 1'b0;
  int   pce1_low = 0;
  always @(negedge clk) if (mon1 && pce1 !== 1'b1) pce1_low++;

  int hs_fall_i, hs_fall_x, hs_low_n, hs_rise_x, blank_fall_i, blank_fall_x, ls_next_i, vs_bad;
  int fs_i1, x_i1, x_i2, cur;
  logic [13:0] act_v, exp_v;

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = mk(0,  4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    vt[1]  = mk(3,  4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vt[2]  = mk(4,  4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    vt[3]  = mk(5,  4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    vt[4]  = mk(6,  4'd6, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    vt[5]  = mk(7,  4'd7, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    vt[6]  = mk(8,  4'd0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    vt[7]  = mk(24, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    vt[8]  = mk(32, 4'd0, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    vt[9]  = mk(37, 4'd5, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    vt[10] = mk(40, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    vt[11] = mk(47, 4'd7, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    vt[12] = mk(48, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    rst0 = 1'b0; rst1 = 1'b0; en0 = 1'b1; en1 = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values with En held high
    chk("rst0_x", 32'(x0), 0);        chk("rst0_y", 32'(y0), 0);
    chk("rst0_blank", 32'(blank0), 0); chk("rst0_ls", 32'(ls0), 0);
    chk("rst0_fs", 32'(fs0), 0);      chk("rst0_busy", 32'(busy0), 0);
    chk("rst0_fc", 32'(fc0), 0);      chk("rst0_ce", 32'(pce0), 0);
    chk("rst0_hs", 32'(hs0), 1);      chk("rst0_vs", 32'(vs0), 1);
    chk("rst0_sync", 32'(sync0), 0);
    chk("rst1_hs", 32'(hs1), 0);      chk("rst1_vs", 32'(vs1), 0);
    chk("rst1_ce", 32'(pce1), 0);     chk("rst1_busy", 32'(busy1), 0);

    // Default instance: release and start latency
    rst0 = 1'b1;
    @(negedge clk); chk("d0_ce_clk1", 32'(pce0), 0);
    @(negedge clk); chk("d0_ce_clk2", 32'(pce0), 1); chk("d0_busy_pre", 32'(busy0), 0);
    @(negedge clk);
    chk("d0_start_fs", 32'(fs0), 1);  chk("d0_start_ls", 32'(ls0), 1);
    chk("d0_start_busy", 32'(busy0), 1); chk("d0_start_blank", 32'(blank0), 1);
    chk("d0_start_xy", 32'({x0, y0}), 0);

    // One full line measured in Clk cycles from the first (0,0) cycle
    hs_fall_i = -1; hs_fall_x = -1; hs_low_n = 0; hs_rise_x = -1;
    blank_fall_i = -1; blank_fall_x = -1; ls_next_i = -1; vs_bad = 0;
    fs_i1 = -1; x_i1 = -1; x_i2 = -1;
    for (int i = 0; i <= 1600; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) begin fs_i1 = int'(fs0); x_i1 = int'(x0); end
      if (i == 2) x_i2 = int'(x0);
      if (hs0 == 1'b0) begin
        hs_low_n++;
        if (hs_fall_i < 0) begin hs_fall_i = i; hs_fall_x = int'(x0); end
      end else if (hs_fall_i >= 0 && hs_rise_x < 0) begin
        hs_rise_x = int'(x0);
      end
      if (blank0 == 1'b0 && blank_fall_i < 0) begin blank_fall_i = i; blank_fall_x = int'(x0); end
      if (i > 0 && ls0 == 1'b1 && ls_next_i < 0) ls_next_i = i;
      if (vs0 !== 1'b1) vs_bad++;
    end
    chk("fs_one_clk", 32'(fs_i1), 0);      chk("x_held_2clk", 32'(x_i1), 0);
    chk("x_step", 32'(x_i2), 1);
    chk("hs_fall_clk", 32'(hs_fall_i), 1312); chk("hs_fall_x", 32'(hs_fall_x), 656);
    chk("hs_low_clks", 32'(hs_low_n), 192);   chk("hs_rise_x", 32'(hs_rise_x), 752);
    chk("blank_fall_clk", 32'(blank_fall_i), 1280); chk("blank_fall_x", 32'(blank_fall_x), 640);
    chk("line_period", 32'(ls_next_i), 1600); chk("vs_idle_line0", 32'(vs_bad), 0);
    chk("line1_xy", 32'({x0, y0}), 32'({10'd0, 10'd1}));

    // Mid-line asynchronous reset
    repeat (600) @(negedge clk);
    chk("d0_x300", 32'(x0), 300);
    @(negedge clk);
    #2 rst0 = 1'b0;
    #1;
    chk("arst0_xy", 32'({x0, y0}), 0);  chk("arst0_busy", 32'(busy0), 0);
    chk("arst0_blank", 32'(blank0), 0); chk("arst0_ce", 32'(pce0), 0);
    chk("arst0_hs", 32'(hs0), 1);

    // In IDLE only En on pixel_ce cycles counts
    @(negedge clk); rst0 = 1'b1; en0 = 1'b1;
    @(negedge clk); chk("d0r_ce1", 32'(pce0), 0);
    @(negedge clk); chk("d0r_ce2", 32'(pce0), 1); en0 = 1'b0;
    @(negedge clk); chk("d0r_no_start", 32'(busy0), 0); en0 = 1'b1;
    @(negedge clk); chk("d0r_ce4", 32'(pce0), 1); chk("d0r_idle", 32'(busy0), 0);
    @(negedge clk);
    chk("d0r_start_busy", 32'(busy0), 1); chk("d0r_start_fs", 32'(fs0), 1);
    chk("d0r_start_xy", 32'({x0, y0}), 0);
    rst0 = 1'b0;

    // Small mode: release, then table of a whole 48-Clk frame
    @(negedge clk); rst1 = 1'b1;
    @(negedge clk); chk("d1_ce_clk1", 32'(pce1), 1); chk("d1_busy_pre", 32'(busy1), 0);
    @(negedge clk);
    cur = 0; mon1 = 1'b1;
    for (int i = 0; i < 13; i++) begin
      en1 = vt[i].en;
      repeat (vt[i].cyc - cur) @(negedge clk);
      cur = vt[i].cyc;
      act_v = {x1, y1, hs1, vs1, blank1, ls1, fs1, busy1};
      exp_v = {vt[i].x, vt[i].y, vt[i].hs, vt[i].vs, vt[i].blank, vt[i].ls, vt[i].fs, vt[i].busy};
      nvec++;
      if (act_v !== exp_v) begin
        nerr++;
        $display("FAIL vec%0d cyc%0d {x,y,hs,vs,blank,ls,fs,busy}: got %0h expected %0h",
                 i, vt[i].cyc, act_v, exp_v);
      end
    end
    chk("d1_fc_1", 32'(fc1), 1);
    chk("d1_sync", 32'(sync1), 0);

    // Stop request mid-frame finishes the frame
    repeat (10) @(negedge clk); en1 = 1'b0;
    repeat (37) @(negedge clk);
    chk("stop_last_busy", 32'(busy1), 1); chk("stop_last_xy", 32'({x1, y1}), 32'({4'd7, 4'd5}));
    @(negedge clk);
    chk("stop_busy", 32'(busy1), 0);   chk("stop_xy", 32'({x1, y1}), 0);
    chk("stop_fc", 32'(fc1), 2);       chk("stop_fs", 32'(fs1), 0);
    chk("stop_blank", 32'(blank1), 0);
    repeat (4) @(negedge clk);
    chk("stop_hold_busy", 32'(busy1), 0); chk("stop_hold_xy", 32'({x1, y1}), 0);

    // Restart, then drop and re-raise En within the frame: no stop
    en1 = 1'b1;
    @(negedge clk); chk("rerun_busy", 32'(busy1), 1); chk("rerun_fs", 32'(fs1), 1);
    repeat (10) @(negedge clk); en1 = 1'b0;
    repeat (16) @(negedge clk);
    chk("cancel_busy", 32'(busy1), 1); chk("cancel_y", 32'(y1), 3);
    en1 = 1'b1;
    repeat (22) @(negedge clk);
    chk("cancel_wrap_fs", 32'(fs1), 1); chk("cancel_wrap_busy", 32'(busy1), 1);
    chk("cancel_wrap_xy", 32'({x1, y1}), 0); chk("cancel_fc", 32'(fc1), 3);

    // Frame counter wraps modulo 16
    repeat (576) @(negedge clk); chk("fc_15", 32'(fc1), 15);
    repeat (48)  @(negedge clk); chk("fc_wrap", 32'(fc1), 0);
    repeat (37)  @(negedge clk);
    chk("d1_sync_xy", 32'({x1, y1}), 32'({4'd5, 4'd4}));
    chk("d1_hs_on", 32'(hs1), 1); chk("d1_vs_on", 32'(vs1), 1);
    mon1 = 1'b0;
    chk("d1_ce_const", 32'(pce1_low), 0);

    // Asynchronous reset while both syncs are asserted
    @(negedge clk);
    #2 rst1 = 1'b0;
    #1;
    chk("arst1_xy", 32'({x1, y1}), 0); chk("arst1_hs", 32'(hs1), 0);
    chk("arst1_vs", 32'(vs1), 0);      chk("arst1_busy", 32'(busy1), 0);
    chk("arst1_fc", 32'(fc1), 0);      chk("arst1_ce", 32'(pce1), 0);
    chk("arst1_blank", 32'(blank1), 0); chk("arst1_marks", 32'({ls1, fs1}), 0);
    @(negedge clk); rst1 = 1'b1;
    @(negedge clk); chk("d1r_ce", 32'(pce1), 1);
    @(negedge clk);
    chk("d1r_busy", 32'(busy1), 1); chk("d1r_fs", 32'(fs1), 1);
    chk("d1r_xy", 32'({x1, y1}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
